// File: rtl/cyclic_lamp_pkg.sv
// -----------------------------------------------------------------------------
// cyclic_lamp_pkg
//   Shared definitions for the cyclic traffic-lamp light bus. The lamp
//   generator and the receive-side monitor both take their codes from here.
//
//   Contents
//     RED / GREEN / YELLOW   one-hot light codes as seen on the bus ([0:2])
//     lamp_state_t           monitor FSM states; the encoding is chosen to be
//                            identical to the cur_color encoding, so the
//                            registered state is the colour output directly
//     COLOR_*                cur_color encodings
//     light_to_state()       decode a bus code to a state (S_IDLE if illegal)
//     next_legal()           successor colour in the G -> Y -> R -> G order
// -----------------------------------------------------------------------------
package cyclic_lamp_pkg;

    localparam logic [0:2] RED    = 3'b100;
    localparam logic [0:2] GREEN  = 3'b010;
    localparam logic [0:2] YELLOW = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_RED    = 2'd3
    } lamp_state_t;

    localparam logic [1:0] COLOR_NONE   = 2'd0;
    localparam logic [1:0] COLOR_GREEN  = 2'd1;
    localparam logic [1:0] COLOR_YELLOW = 2'd2;
    localparam logic [1:0] COLOR_RED    = 2'd3;

    // Any code that is not exactly one of the three lamp codes maps to
    // S_IDLE, which the monitor treats as "not one-hot".
    function automatic lamp_state_t light_to_state(input logic [0:2] code);
        lamp_state_t s;
        case (code)
            GREEN:   s = S_GREEN;
            YELLOW:  s = S_YELLOW;
            RED:     s = S_RED;
            default: s = S_IDLE;
        endcase
        return s;
    endfunction

    function automatic lamp_state_t next_legal(input lamp_state_t s);
        lamp_state_t n;
        case (s)
            S_GREEN:  n = S_YELLOW;
            S_YELLOW: n = S_RED;
            S_RED:    n = S_GREEN;
            default:  n = S_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lamp_dwell_counter.sv
// -----------------------------------------------------------------------------
// lamp_dwell_counter
//   Counts how many consecutive clocks the current colour has been on.
//   Saturates at 2^CNT_W-1 so a lamp stuck on forever never wraps back
//   through MAX_DWELL and re-fires the timeout.
//
//   Ports
//     clk, rst_n   clock / asynchronous active-low reset
//     clear        dwell <= 0 (lamp code lost)
//     load1        dwell <= 1 (first clock of a new colour)
//     incr         dwell <= dwell + 1, saturating (same colour again)
//     crossing     combinational: this edge takes dwell from MAX_DWELL to
//                  MAX_DWELL+1 (lets the owner update sticky state in step)
//     crossed      registered version of crossing; a 1-clk pulse per
//                  dwell episode
//   Control priority is clear > load1 > incr; the owner drives at most one.
// -----------------------------------------------------------------------------
module lamp_dwell_counter #(
    parameter int CNT_W     = 8,
    parameter int MAX_DWELL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load1,
    input  logic incr,
    output logic crossing,
    output logic crossed
);

    localparam logic [CNT_W-1:0] MAX_D = CNT_W'(MAX_DWELL);
    localparam logic [CNT_W-1:0] SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] dwell_d;

    // MAX_DWELL is below the saturation value, so the crossing can only
    // happen once between two loads.
    assign crossing = incr && !clear && !load1 && (dwell == MAX_D);

    always_comb begin
        dwell_d = dwell;
        if (clear) begin
            dwell_d = '0;
        end else if (load1) begin
            dwell_d = ONE;
        end else if (incr && (dwell != SAT)) begin
            dwell_d = dwell + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell   <= '0;
            crossed <= 1'b0;
        end else begin
            dwell   <= dwell_d;
            crossed <= crossing;
        end
    end

endmodule

// File: rtl/cyclic_lamp_monitor.sv
// -----------------------------------------------------------------------------
// cyclic_lamp_monitor
//   Receive-side checker for the cyclic traffic-lamp bus. Every clock it
//   checks that the light code is one-hot, that colours follow
//   G -> Y -> R -> G, and that no colour stays on longer than MAX_DWELL
//   clocks. Full cycles are counted; errors give 1-clk pulses and a sticky
//   flag. All outputs are registered one edge after the sampled code.
//
//   Ports
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     light        lamp code [0:2]: red=100, green=010, yellow=001
//     clr_err      synchronous clear of err_sticky (an error on the same
//                  edge takes precedence)
//     cur_color    0=none/unlocked, 1=green, 2=yellow, 3=red; this is the
//                  FSM state register itself
//     locked       high while tracking a valid colour
//     code_err     pulse: light was not one-hot
//     seq_err      pulse: illegal colour transition
//     timeout_err  pulse: dwell went past MAX_DWELL
//     err_sticky   OR of error pulses since last clear/reset
//     cycle_count  completed G->Y->R->G cycles, wraps mod 2^CNT_W
// -----------------------------------------------------------------------------
module cyclic_lamp_monitor
    import cyclic_lamp_pkg::*;
#(
    parameter int MAX_DWELL = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:2]       light,
    input  logic             clr_err,
    output logic [1:0]       cur_color,
    output logic             locked,
    output logic             code_err,
    output logic             seq_err,
    output logic             timeout_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    lamp_state_t state;
    lamp_state_t state_d;
    lamp_state_t in_state;
    logic        in_valid;

    // armed: a green has been entered through a path that started a cycle
    // we are allowed to count; the partial cycle seen after lock-on or a
    // resync is not counted.
    logic armed;
    logic armed_d;
    logic count_inc;
    logic code_err_d;
    logic seq_err_d;
    logic dw_clear;
    logic dw_load1;
    logic dw_incr;
    logic timeout_d;

    assign in_state = light_to_state(light);
    assign in_valid = (in_state != S_IDLE);

    // Next-state / control decode. The branches are mutually exclusive and
    // ordered exactly as the evaluation order of the checker: bad code
    // first, then lock-on from idle, then hold, legal step, illegal step.
    always_comb begin
        state_d    = state;
        armed_d    = armed;
        count_inc  = 1'b0;
        code_err_d = 1'b0;
        seq_err_d  = 1'b0;
        dw_clear   = 1'b0;
        dw_load1   = 1'b0;
        dw_incr    = 1'b0;

        if (!in_valid) begin
            code_err_d = 1'b1;
            state_d    = S_IDLE;
            armed_d    = 1'b0;
            dw_clear   = 1'b1;
        end else if (state == S_IDLE) begin
            state_d  = in_state;
            dw_load1 = 1'b1;
            armed_d  = (in_state == S_GREEN);
        end else if (in_state == state) begin
            dw_incr = 1'b1;
        end else if (in_state == next_legal(state)) begin
            state_d  = in_state;
            dw_load1 = 1'b1;
            if (in_state == S_GREEN) begin
                count_inc = armed;
                armed_d   = 1'b1;
            end
        end else begin
            seq_err_d = 1'b1;
            state_d   = in_state;
            dw_load1  = 1'b1;
            armed_d   = (in_state == S_GREEN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_d;
            armed <= armed_d;
        end
    end

    lamp_dwell_counter #(
        .CNT_W     (CNT_W),
        .MAX_DWELL (MAX_DWELL)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (dw_clear),
        .load1    (dw_load1),
        .incr     (dw_incr),
        .crossing (timeout_d),
        .crossed  (timeout_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_err    <= 1'b0;
            seq_err     <= 1'b0;
            err_sticky  <= 1'b0;
            cycle_count <= '0;
        end else begin
            code_err <= code_err_d;
            seq_err  <= seq_err_d;
            // A new error on this edge beats a coincident clear.
            if (code_err_d || seq_err_d || timeout_d) begin
                err_sticky <= 1'b1;
            end else if (clr_err) begin
                err_sticky <= 1'b0;
            end
            if (count_inc) begin
                cycle_count <= cycle_count + CNT_ONE;
            end
        end
    end

    assign cur_color = state;
    assign locked    = (state != S_IDLE);

endmodule

// File: tb/tb_cyclic_lamp_monitor.sv
// -----------------------------------------------------------------------------
// tb_cyclic_lamp_monitor
//   Two monitors share one stimulus stream: one with CNT_W=8 and one with
//   CNT_W=2 (to exercise cycle_count wrap and dwell saturation). A colour-
//   level model predicts every output; a compare process checks both DUTs
//   on every falling edge, and directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_cyclic_lamp_monitor;

    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_GREEN  = 3'b010;
    localparam logic [2:0] L_YELLOW = 3'b001;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic [0:2] light = 3'b010;
    logic clr_err = 1'b0;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic [1:0] a_color, b_color;
    logic       a_locked, b_locked;
    logic       a_code, b_code, a_seq, b_seq, a_to, b_to, a_sticky, b_sticky;
    logic [7:0] a_count;
    logic [1:0] b_count;

    cyclic_lamp_monitor #(.MAX_DWELL(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .light(light), .clr_err(clr_err),
        .cur_color(a_color), .locked(a_locked), .code_err(a_code),
        .seq_err(a_seq), .timeout_err(a_to), .err_sticky(a_sticky),
        .cycle_count(a_count)
    );

    cyclic_lamp_monitor #(.MAX_DWELL(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .light(light), .clr_err(clr_err),
        .cur_color(b_color), .locked(b_locked), .code_err(b_code),
        .seq_err(b_seq), .timeout_err(b_to), .err_sticky(b_sticky),
        .cycle_count(b_count)
    );

    // ---------------- checking core ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Colours: 0 none, 1 green, 2 yellow, 3 red. Legal successor of c is c%3+1.
    int m_col   = 0;
    int m_dwell = 0;
    bit m_armed = 0;
    int m_count = 0;
    bit m_code = 0, m_seq = 0, m_to = 0, m_sticky = 0;

    function automatic int colour_of(input logic [2:0] l);
        if ($countones(l) != 1) return 0;
        if (l == L_GREEN)  return 1;
        if (l == L_YELLOW) return 2;
        return 3;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_col = 0; m_dwell = 0; m_armed = 0; m_count = 0;
            m_code = 0; m_seq = 0; m_to = 0; m_sticky = 0;
        end else begin
            int c;
            c = colour_of(light);
            m_code = 0; m_seq = 0; m_to = 0;
            if (c == 0) begin
                m_code = 1; m_col = 0; m_dwell = 0; m_armed = 0;
            end else if (m_col == 0) begin
                m_col = c; m_dwell = 1; m_armed = (c == 1);
            end else if (c == m_col) begin
                m_dwell++;
                if (m_dwell == 2) m_to = 1;   // MAX_DWELL+1, unbounded count
            end else if (c == (m_col % 3) + 1) begin
                if (c == 1) begin
                    if (m_armed) m_count++;
                    m_armed = 1;
                end
                m_col = c; m_dwell = 1;
            end else begin
                m_seq = 1; m_col = c; m_dwell = 1; m_armed = (c == 1);
            end
            if (m_code || m_seq || m_to) m_sticky = 1;
            else if (clr_err) m_sticky = 0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("a_color",  32'(a_color),  32'(m_col));
        chk("a_locked", 32'(a_locked), 32'(m_col != 0));
        chk("a_code",   32'(a_code),   32'(m_code));
        chk("a_seq",    32'(a_seq),    32'(m_seq));
        chk("a_to",     32'(a_to),     32'(m_to));
        chk("a_sticky", 32'(a_sticky), 32'(m_sticky));
        chk("a_count",  32'(a_count),  32'(m_count % 256));
        chk("b_color",  32'(b_color),  32'(m_col));
        chk("b_to",     32'(b_to),     32'(m_to));
        chk("b_sticky", 32'(b_sticky), 32'(m_sticky));
        chk("b_count",  32'(b_count),  32'(m_count % 4));
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the next falling edge, when the
    // outputs reflect the code just driven.
    task automatic step(input logic [2:0] l, input logic c = 1'b0);
        light   = l;
        clr_err = c;
        @(negedge clk);
    endtask

    // Reset asserted away from any clock edge, released at a falling edge
    // with the first code already on the bus.
    task automatic do_reset(input logic [2:0] first);
        #2 rst_n = 1'b0;
        light   = first;
        clr_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_color",  32'(a_color),  0);
        chk("rst_locked", 32'(a_locked), 0);
        chk("rst_count",  32'(a_count),  0);
        chk("rst_sticky", 32'(a_sticky), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: full cycles from green
        chk("t1_first_green", 32'(a_color), 1);
        step(L_YELLOW);
        chk("t1_yellow", 32'(a_color), 2);
        step(L_RED); step(L_GREEN);
        chk("t1_count1", 32'(a_count), 1);
        step(L_YELLOW); step(L_RED); step(L_GREEN);
        chk("t1_count2", 32'(a_count), 2);
        chk("t1_sticky", 32'(a_sticky), 0);

        // 2: start at yellow, first partial cycle not counted
        do_reset(L_YELLOW);
        chk("t2_locked", 32'(a_locked), 1);
        chk("t2_color",  32'(a_color), 2);
        step(L_RED); step(L_GREEN);
        chk("t2_partial", 32'(a_count), 0);
        step(L_YELLOW); step(L_RED); step(L_GREEN);
        chk("t2_count", 32'(a_count), 1);

        // 3: bad code
        do_reset(L_GREEN);
        step(3'b110);
        chk("t3_code_err", 32'(a_code), 1);
        chk("t3_locked",   32'(a_locked), 0);
        chk("t3_color",    32'(a_color), 0);
        chk("t3_sticky",   32'(a_sticky), 1);
        step(L_GREEN);
        chk("t3_relock", 32'(a_locked), 1);
        chk("t3_no_seq", 32'(a_seq), 0);

        // 4: illegal G->R, then hold green
        do_reset(L_GREEN);
        step(L_RED);
        chk("t4_seq_err", 32'(a_seq), 1);
        chk("t4_color",   32'(a_color), 3);
        step(L_GREEN);
        chk("t4_to_g1", 32'(a_to), 0);
        chk("t4_no_count", 32'(a_count), 0);
        step(L_GREEN);
        chk("t4_to_g2", 32'(a_to), 1);
        step(L_GREEN);
        chk("t4_to_g3", 32'(a_to), 0);

        // 5: clear coincident with an error, then alone
        step(L_RED, 1'b1);
        chk("t5_seq",       32'(a_seq), 1);
        chk("t5_set_wins",  32'(a_sticky), 1);
        step(L_GREEN, 1'b1);
        chk("t5_cleared",   32'(a_sticky), 0);
        // long hold: CNT_W=2 dwell saturates and must not re-fire
        for (int i = 0; i < 6; i++) step(L_GREEN);
        chk("t5_sat_no_to", 32'(b_to), 0);
        chk("t5_sat_stk",   32'(b_sticky), 1);

        // 6: wrap on CNT_W=2, then asynchronous reset mid-cycle
        do_reset(L_GREEN);
        for (int k = 1; k <= 5; k++) begin
            step(L_YELLOW); step(L_RED); step(L_GREEN);
            if (k == 3) chk("t6_b_count3", 32'(b_count), 3);
            if (k == 4) chk("t6_b_wrap0",  32'(b_count), 0);
        end
        chk("t6_b_wrap1", 32'(b_count), 1);
        chk("t6_a_count5", 32'(a_count), 5);
        step(L_YELLOW);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_color", 32'(a_color), 0);
        chk("t6_async_lock",  32'(a_locked), 0);
        chk("t6_async_a_cnt", 32'(a_count), 0);
        chk("t6_async_b_cnt", 32'(b_count), 0);
        @(negedge clk);
        light = L_RED;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_restart_red", 32'(a_color), 3);
        step(L_GREEN); step(L_YELLOW); step(L_RED); step(L_GREEN);
        chk("t6_restart_cnt", 32'(a_count), 1);
        chk("t6_no_err",      32'(a_sticky), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
